// File: rtl/spi_reg_controller.sv
// spi_reg_controller: SPI mode-0 write-only frame receiver committing 16-bit frames into a config register bank
module spi_reg_controller #(
   parameter int NUM_REGS    = 5,
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       sclk,
   input  logic                       copi,
   input  logic                       ncs,
   output logic [NUM_REGS*DATA_W-1:0] regs_o,
   output logic                       wr_strobe,
   output logic [6:0]                 wr_addr,
   output logic                       frame_err
);
   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, DISCARD} state_e;
   localparam logic [6:0] NREG = 7'(NUM_REGS);
   logic [1:0]                 rst_sync_q;
   logic                       arst_n;
   logic [SYNC_STAGES-1:0]     sclk_q, copi_q, ncs_q, vld_q;
   logic                       sclk_hist_q, ncs_hist_q, armed_q;
   logic                       sclk_s, copi_s, ncs_s, sclk_rise, ncs_rise, ncs_fall, hold;
   state_e                     state_q, state_d;
   logic [4:0]                 bit_cnt_q, bit_cnt_d;
   logic [15:0]                shift_q, shift_d;
   logic [NUM_REGS*DATA_W-1:0] regs_q;
   logic                       wr_strobe_q, frame_err_q;
   logic [6:0]                 wr_addr_q;
   logic                       frame_ok, is_read;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rst_sync_q <= '0;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   assign arst_n = rst_sync_q[1];

   assign sclk_s    = sclk_q[SYNC_STAGES-1];
   assign copi_s    = copi_q[SYNC_STAGES-1];
   assign ncs_s     = ncs_q[SYNC_STAGES-1];
   assign hold      = (state_q == COMMIT) || (state_q == DISCARD);
   assign sclk_rise = sclk_s & ~sclk_hist_q;
   assign ncs_rise  = ncs_s & ~ncs_hist_q;
   // a frame already running at reset release never arms, so its fall is ignored
   assign ncs_fall  = ~ncs_s & ncs_hist_q & armed_q;

   always_ff @(posedge clk or negedge arst_n)
      if (!arst_n) begin
         sclk_q      <= '0;
         copi_q      <= '0;
         ncs_q       <= '1;
         vld_q       <= '0;
         sclk_hist_q <= 1'b0;
         ncs_hist_q  <= 1'b1;
         armed_q     <= 1'b0;
      end else begin
         sclk_q      <= {sclk_q[SYNC_STAGES-2:0], sclk};
         copi_q      <= {copi_q[SYNC_STAGES-2:0], copi};
         ncs_q       <= {ncs_q[SYNC_STAGES-2:0], ncs};
         vld_q       <= {vld_q[SYNC_STAGES-2:0], 1'b1};
         sclk_hist_q <= sclk_s;
         ncs_hist_q  <= hold ? ncs_hist_q : ncs_s;
         armed_q     <= armed_q | (vld_q[SYNC_STAGES-1] & ncs_s);
      end

   assign frame_ok = (bit_cnt_q == 5'd16) && shift_q[15] && (shift_q[14:8] < NREG);
   assign is_read  = (bit_cnt_q == 5'd16) && !shift_q[15];

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      case (state_q)
         IDLE:
            if (ncs_fall) begin
               state_d   = SHIFT;
               bit_cnt_d = '0;
               shift_d   = '0;
            end
         SHIFT:
            if (ncs_rise) state_d = frame_ok ? COMMIT : DISCARD;
            else if (sclk_rise) begin
               shift_d   = {shift_q[14:0], copi_s};
               bit_cnt_d = (bit_cnt_q == 5'd17) ? bit_cnt_q : bit_cnt_q + 5'd1;
            end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n)
      if (!arst_n) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         regs_q      <= '0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         wr_strobe_q <= state_q == COMMIT;
         frame_err_q <= (state_q == DISCARD) && !is_read;
         if (state_q == COMMIT) begin
            regs_q[int'(shift_q[14:8])*DATA_W +: DATA_W] <= shift_q[DATA_W-1:0];
            wr_addr_q <= shift_q[14:8];
         end
      end

   assign regs_o    = regs_q;
   assign wr_strobe = wr_strobe_q;
   assign wr_addr   = wr_addr_q;
   assign frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_reg_controller.sv
// tb_spi_reg_controller: directed SPI frames with an expected-event queue checked by an output monitor
module tb_spi_reg_controller;
   logic        clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, copi = 1'b0, ncs = 1'b1;
   logic [39:0] regs_o;
   logic        wr_strobe, frame_err;
   logic [6:0]  wr_addr;
   typedef struct packed {logic err; logic [6:0] addr; logic [39:0] bank;} exp_t;
   exp_t        q[$];
   logic [39:0] model = '0;
   int          checks = 0, errors = 0;

   spi_reg_controller dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
      .regs_o(regs_o), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (rst_n && (wr_strobe || frame_err)) begin
         if (q.size() == 0) check("unexpected_event", 64'({wr_strobe, frame_err}), 64'd0);
         else begin
            exp_t e;
            e = q.pop_front();
            check("event_kind", 64'({wr_strobe, frame_err}), e.err ? 64'd1 : 64'd2);
            if (!e.err) check("wr_addr", 64'(wr_addr), 64'(e.addr));
            check("bank", 64'(regs_o), 64'(e.bank));
         end
      end
   end

   task automatic shift_bits(input logic [31:0] w, input int hi, input int lo);
      for (int i = hi; i >= lo; i--) begin
         copi = w[i];
         #40 sclk = 1'b1;
         #40 sclk = 1'b0;
      end
   endtask

   task automatic send(input logic [31:0] w, input int n);
      ncs = 1'b0;
      #40;
      shift_bits(w, n - 1, 0);
      #40 ncs = 1'b1;
      #80;
   endtask

   task automatic wr(input logic [6:0] a, input logic [7:0] d);
      model[int'(a)*8 +: 8] = d;
      q.push_back({1'b0, a, model});
      send({16'h0, 1'b1, a, d}, 16);
   endtask

   task automatic bad(input logic [31:0] w, input int n);
      q.push_back({1'b1, 7'd0, model});
      send(w, n);
   endtask

   initial begin
      #23 rst_n = 1'b1;
      #100;
      check("rst_regs", 64'(regs_o), 64'd0);
      check("rst_strobe", 64'(wr_strobe), 64'd0);
      check("rst_addr", 64'(wr_addr), 64'd0);
      check("rst_err", 64'(frame_err), 64'd0);
      wr(7'd0, 8'h27);
      wr(7'd1, 8'hE7);
      wr(7'd2, 8'h96);
      wr(7'd3, 8'h85);
      wr(7'd4, 8'h11);
      check("bank_t2", 64'(regs_o), 64'h11_85_96_E7_27);
      bad(32'h85FF, 16);
      bad(32'h802, 12);
      bad(32'h8027F, 20);
      send(32'h00AA, 16);
      #200;
      check("bank_t5", 64'(regs_o), 64'h11_85_96_E7_27);
      ncs = 1'b0;
      #40;
      shift_bits(32'h8233, 15, 6);
      rst_n = 1'b0;
      model = '0;
      #25;
      check("bank_rst", 64'(regs_o), 64'd0);
      rst_n = 1'b1;
      shift_bits(32'h8233, 5, 0);
      #40 ncs = 1'b1;
      #200;
      wr(7'd2, 8'h5A);
      #300;
      check("bank_final", 64'(regs_o), 64'h00_00_5A_00_00);
      check("pending", 64'(q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
